// File: rtl/rans_byte_packer.sv
// Byte packer behind the multi-stream rANS encoder: merges up to two qualified bytes
// per cycle into 32-bit little-endian words, queues them, and closes streams on flush.

module rbp_slot #(
  parameter int SW  = 8,
  parameter int IDX = 0
) (
  input  logic [1:0]    i_fill,
  input  logic [SW-1:0] i_acc,
  input  logic [SW-1:0] i_b0,
  input  logic [SW-1:0] i_b1,
  output logic [SW-1:0] o_byte
);
  localparam logic [2:0] K = 3'(IDX);
  logic [2:0] w_f0, w_f1;
  assign w_f0 = {1'b0, i_fill};
  assign w_f1 = w_f0 + 3'd1;

  // Slot K keeps an already-pending byte, else takes the first or second new byte.
  always_comb begin
    o_byte = '0;
    if (K < w_f0)       o_byte = i_acc;
    else if (K == w_f0) o_byte = i_b0;
    else if (K == w_f1) o_byte = i_b1;
  end
endmodule

module rans_byte_packer #(
  parameter int SYMBOL_WIDTH = 8,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [1:0]                valid_i,
  input  logic [2*SYMBOL_WIDTH-1:0] enc_i,
  input  logic                      flush_i,
  output logic                      busy_o,
  output logic                      flush_done_o,
  output logic                      overflow_o,
  output logic                      protocol_err_o,
  output logic [4*SYMBOL_WIDTH-1:0] m_data_o,
  output logic [3:0]                m_keep_o,
  output logic                      m_last_o,
  output logic                      m_valid_o,
  input  logic                      m_ready_i
);
  localparam int SW = SYMBOL_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic {ST_RUN, ST_FLUSH} state_t;

  typedef struct packed {
    logic [3:0][SW-1:0] data;
    logic [3:0]         keep;
    logic               last;
  } word_t;

  state_t               r_state, w_state_nxt;
  logic [2:0][SW-1:0]   r_acc, w_acc_nxt;
  logic [1:0]           r_fill, w_fill_nxt;
  logic [AW:0]          r_wptr, r_rptr;
  word_t                r_mem [FIFO_DEPTH];
  logic                 r_pushed_prev;
  logic                 r_done, r_ovf, r_perr;

  logic [SW-1:0]        w_b0, w_b1;
  logic [1:0]           w_n;
  logic [4:0][SW-1:0]   w_accx, w_cat;
  logic [2:0]           w_sum, w_rem;
  logic [3:0]           w_keep_f;
  logic [3:0][SW-1:0]   w_flush_data;
  word_t                w_word, w_head;
  logic                 w_push, w_set_last;
  logic                 w_empty, w_full, w_pop, w_push_ok, w_drop, w_tail_live;
  logic [AW:0]          w_count;
  logic [AW-1:0]        w_tail_idx;

  // Lane ordering: the low lane always precedes the high lane.
  always_comb begin
    w_b0 = '0;
    w_b1 = '0;
    w_n  = 2'd0;
    case (valid_i)
      2'b01: begin w_b0 = enc_i[SW-1:0];    w_n = 2'd1; end
      2'b10: begin w_b0 = enc_i[2*SW-1:SW]; w_n = 2'd1; end
      2'b11: begin w_b0 = enc_i[SW-1:0]; w_b1 = enc_i[2*SW-1:SW]; w_n = 2'd2; end
      default: ;
    endcase
  end

  assign w_accx = {{(2*SW){1'b0}}, r_acc};
  assign w_sum  = {1'b0, r_fill} + {1'b0, w_n};
  assign w_rem  = w_sum - 3'd4;

  for (genvar k = 0; k < 5; k++) begin : g_slot
    rbp_slot #(.SW(SW), .IDX(k)) u_slot (
      .i_fill (r_fill),
      .i_acc  (w_accx[k]),
      .i_b0   (w_b0),
      .i_b1   (w_b1),
      .o_byte (w_cat[k])
    );
  end

  // Flush word: pending bytes with stale upper bytes zeroed.
  always_comb begin
    w_keep_f = 4'b0000;
    case (r_fill)
      2'd1: w_keep_f = 4'b0001;
      2'd2: w_keep_f = 4'b0011;
      2'd3: w_keep_f = 4'b0111;
      default: ;
    endcase
    w_flush_data = '0;
    for (int k = 0; k < 3; k++)
      if (w_keep_f[k]) w_flush_data[k] = r_acc[k];
  end

  assign w_empty     = (r_wptr == r_rptr);
  assign w_full      = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop       = !w_empty && m_ready_i;
  assign w_count     = r_wptr - r_rptr;
  assign w_tail_idx  = r_wptr[AW-1:0] - AW'(1);
  // The tail is still markable only if it is not leaving on this very edge.
  assign w_tail_live = !w_empty && !(w_pop && (w_count == (AW+1)'(1)));

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_fill_nxt  = r_fill;
    w_push      = 1'b0;
    w_set_last  = 1'b0;
    w_word      = '0;
    case (r_state)
      ST_RUN: begin
        if (w_sum >= 3'd4) begin
          w_push      = 1'b1;
          w_word.data = w_cat[3:0];
          w_word.keep = 4'b1111;
          w_acc_nxt   = {{(2*SW){1'b0}}, w_cat[4]};
          w_fill_nxt  = w_rem[1:0];
        end else begin
          w_acc_nxt   = w_cat[2:0];
          w_fill_nxt  = w_sum[1:0];
        end
        if (flush_i) w_state_nxt = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (r_fill != 2'd0) begin
          w_push      = 1'b1;
          w_word.data = w_flush_data;
          w_word.keep = w_keep_f;
          w_word.last = 1'b1;
          w_acc_nxt   = '0;
          w_fill_nxt  = 2'd0;
        end else if (r_pushed_prev && w_tail_live) begin
          w_set_last  = 1'b1;
        end
        w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  // A same-edge pop frees a slot, so a full FIFO can still accept.
  assign w_push_ok = w_push && (!w_full || w_pop);
  assign w_drop    = w_push && w_full && !w_pop;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state       <= ST_RUN;
      r_acc         <= '0;
      r_fill        <= 2'd0;
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_pushed_prev <= 1'b0;
      r_done        <= 1'b0;
      r_ovf         <= 1'b0;
      r_perr        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_acc         <= w_acc_nxt;
      r_fill        <= w_fill_nxt;
      if (w_push_ok) r_wptr <= r_wptr + (AW+1)'(1);
      if (w_pop)     r_rptr <= r_rptr + (AW+1)'(1);
      r_pushed_prev <= w_push_ok;
      r_done        <= (r_state == ST_FLUSH);
      if (w_drop) r_ovf <= 1'b1;
      if (r_state == ST_FLUSH && valid_i != 2'b00) r_perr <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push_ok)       r_mem[r_wptr[AW-1:0]] <= w_word;
    else if (w_set_last) r_mem[w_tail_idx].last <= 1'b1;
  end

  assign w_head         = w_empty ? '0 : r_mem[r_rptr[AW-1:0]];
  assign m_valid_o      = !w_empty;
  assign m_data_o       = w_head.data;
  assign m_keep_o       = w_head.keep;
  assign m_last_o       = w_head.last;
  assign busy_o         = (r_state == ST_FLUSH);
  assign flush_done_o   = r_done;
  assign overflow_o     = r_ovf;
  assign protocol_err_o = r_perr;
endmodule

// File: tb/tb_rans_byte_packer.sv
// Directed bench for rans_byte_packer with a 4-entry FIFO.
module tb_rans_byte_packer;
  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [1:0]  valid_i;
  logic [15:0] enc_i;
  logic        flush_i;
  logic        busy_o, flush_done_o, overflow_o, protocol_err_o;
  logic [31:0] m_data_o;
  logic [3:0]  m_keep_o;
  logic        m_last_o, m_valid_o, m_ready_i;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_w [4];

  rans_byte_packer #(.SYMBOL_WIDTH(8), .FIFO_DEPTH(4)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .valid_i        (valid_i),
    .enc_i          (enc_i),
    .flush_i        (flush_i),
    .busy_o         (busy_o),
    .flush_done_o   (flush_done_o),
    .overflow_o     (overflow_o),
    .protocol_err_o (protocol_err_o),
    .m_data_o       (m_data_o),
    .m_keep_o       (m_keep_o),
    .m_last_o       (m_last_o),
    .m_valid_o      (m_valid_o),
    .m_ready_i      (m_ready_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_word(input string tag, input logic [31:0] d, input logic [3:0] k, input logic l);
    chk({tag, "_valid"}, 32'(m_valid_o), 32'd1);
    chk({tag, "_data"},  m_data_o, d);
    chk({tag, "_keep"},  32'(m_keep_o), 32'(k));
    chk({tag, "_last"},  32'(m_last_o), 32'(l));
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_valid"}, 32'(m_valid_o), 32'd0);
    chk({tag, "_data"},  m_data_o, 32'd0);
    chk({tag, "_keep"},  32'(m_keep_o), 32'd0);
    chk({tag, "_last"},  32'(m_last_o), 32'd0);
    chk({tag, "_busy"},  32'(busy_o), 32'd0);
    chk({tag, "_done"},  32'(flush_done_o), 32'd0);
    chk({tag, "_ovf"},   32'(overflow_o), 32'd0);
    chk({tag, "_perr"},  32'(protocol_err_o), 32'd0);
  endtask

  initial begin
    rst_ni = 1'b0; valid_i = 2'b00; enc_i = 16'h0; flush_i = 1'b0; m_ready_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    chk_idle_outs("reset");
    rst_ni = 1'b1;

    // Two full-lane beats make one word.
    valid_i = 2'b11; enc_i = 16'h2211; step();
    chk("pack_early_valid", 32'(m_valid_o), 32'd0);
    enc_i = 16'h4433; step();
    chk_word("pack", 32'h44332211, 4'hF, 1'b0);
    valid_i = 2'b00; step();
    chk("pack_popped", 32'(m_valid_o), 32'd0);

    // Mixed lanes with carry-over, then flush of two pending bytes.
    valid_i = 2'b01; enc_i = 16'h00A1; step();
    valid_i = 2'b10; enc_i = 16'hB200; step();
    valid_i = 2'b11; enc_i = 16'hD4C3; step();
    chk_word("mixed", 32'hD4C3B2A1, 4'hF, 1'b0);
    enc_i = 16'hF6E5; step();
    chk("mixed_popped", 32'(m_valid_o), 32'd0);
    valid_i = 2'b00; flush_i = 1'b1; step();
    chk("flush2_busy", 32'(busy_o), 32'd1);
    chk("flush2_noword", 32'(m_valid_o), 32'd0);
    flush_i = 1'b0; step();
    chk_word("flush2", 32'h0000F6E5, 4'b0011, 1'b1);
    chk("flush2_done", 32'(flush_done_o), 32'd1);
    chk("flush2_busy_off", 32'(busy_o), 32'd0);
    step();
    chk("flush2_done_pulse", 32'(flush_done_o), 32'd0);
    chk("flush2_popped", 32'(m_valid_o), 32'd0);

    // Flush with exactly four bytes pending under backpressure.
    m_ready_i = 1'b0;
    valid_i = 2'b11; enc_i = 16'h0201; step();
    enc_i = 16'h0403; flush_i = 1'b1; step();
    chk_word("flush4_pre", 32'h04030201, 4'hF, 1'b0);
    valid_i = 2'b00; flush_i = 1'b0; step();
    chk_word("flush4", 32'h04030201, 4'hF, 1'b1);
    chk("flush4_done", 32'(flush_done_o), 32'd1);
    m_ready_i = 1'b1; step();
    chk("flush4_no_extra", 32'(m_valid_o), 32'd0);
    chk("perr_clear", 32'(protocol_err_o), 32'd0);

    // Overflow: 20 bytes into a 4-deep FIFO with no drain.
    m_ready_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      valid_i = 2'b11;
      enc_i = {8'(8'h11 + 2 * i), 8'(8'h10 + 2 * i)};
      step();
      if (i == 7) chk("ovf_not_yet", 32'(overflow_o), 32'd0);
    end
    valid_i = 2'b00;
    chk("ovf_set", 32'(overflow_o), 32'd1);
    chk("ovf_head_held", m_data_o, 32'h13121110);
    exp_w[0] = 32'h13121110; exp_w[1] = 32'h17161514;
    exp_w[2] = 32'h1B1A1918; exp_w[3] = 32'h1F1E1D1C;
    for (int i = 0; i < 4; i++) begin
      chk("drain_valid", 32'(m_valid_o), 32'd1);
      chk("drain_data", m_data_o, exp_w[i]);
      m_ready_i = 1'b1;
      step();
    end
    chk("drain_empty", 32'(m_valid_o), 32'd0);

    // Input during FLUSH is dropped and flagged.
    flush_i = 1'b1; step();
    chk("perr_busy", 32'(busy_o), 32'd1);
    flush_i = 1'b0; valid_i = 2'b11; enc_i = 16'hBBAA; step();
    chk("perr_set", 32'(protocol_err_o), 32'd1);
    chk("perr_done", 32'(flush_done_o), 32'd1);
    chk("perr_nothing", 32'(m_valid_o), 32'd0);
    enc_i = 16'h0201; step();
    enc_i = 16'h0403; step();
    chk_word("perr_unpacked", 32'h04030201, 4'hF, 1'b0);
    valid_i = 2'b00; step();

    // Asynchronous reset with three bytes pending.
    valid_i = 2'b11; enc_i = 16'h2211; step();
    valid_i = 2'b01; enc_i = 16'h0033; step();
    valid_i = 2'b00;
    rst_ni = 1'b0;
    #1;
    chk_idle_outs("async_rst");
    @(negedge clk_i);
    rst_ni = 1'b1;
    valid_i = 2'b11; enc_i = 16'h6655; step();
    chk("fresh_partial", 32'(m_valid_o), 32'd0);
    enc_i = 16'h8877; step();
    chk_word("fresh", 32'h88776655, 4'hF, 1'b0);
    valid_i = 2'b00; step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
